// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// indices of the buttons that carry a control meaning.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RELEASING = 2'd1,
        ST_RUN       = 2'd2,
        ST_RESERVED  = 2'd3
    } state_e;

    localparam int BTN_RUN   = 0;
    localparam int BTN_HALT  = 1;
    localparam int BTN_PULSE = 2;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's button inputs and status/reset outputs.
// The sequencer itself uses the slave view; whoever drives the buttons
// and watches the resets uses the master view.
interface reset_sequencer_if #(
    parameter int N_BTN     = 3,
    parameter int N_DOMAINS = 2
);
    import reset_sequencer_pkg::*;

    logic [N_BTN-1:0]     btn_n;
    logic [N_DOMAINS-1:0] nRstOut;
    logic [N_BTN-1:0]     btnLevel;
    state_e               state;
    logic [7:0]           seqCount;

    modport master (
        output btn_n,
        input  nRstOut,
        input  btnLevel,
        input  state,
        input  seqCount
    );

    modport slave (
        input  btn_n,
        output nRstOut,
        output btnLevel,
        output state,
        output seqCount
    );

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// One push button: two-flop synchroniser, stability counter, debounced
// level (1 = pressed) and a one-cycle press pulse one cycle after the
// level turns to pressed. Releases produce no pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic nRst,
    input  logic btn_n,
    output logic level,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Counting from zero, the flip happens on the edge that would bring the
    // counter to DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d_q;
    logic             press_q;
    logic             pressed_now;

    // Synchronise the raw button; idle (released) value is 1.
    // NOTE: non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], btn_n};
    end

    assign pressed_now = ~sync_q[1];

    // Count consecutive cycles where the synchronised value disagrees with
    // the accepted level; accept the change once it has been stable enough.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (pressed_now == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered press pulse on the cycle after the level rises.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            level_d_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            level_d_q <= level_q;
            press_q   <= level_q & ~level_d_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces the buttons, then releases N_DOMAINS reset
// outputs one after another, STRETCH_CYCLES apart, on a RUN or PULSE
// press. HALT pulls every domain back into reset at once.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int N_DOMAINS       = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STRETCH_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               nRst,
    reset_sequencer_if.slave   bus
);
    localparam int REL_W = $clog2(N_DOMAINS * STRETCH_CYCLES + 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(N_DOMAINS * STRETCH_CYCLES);

    logic [N_BTN-1:0]     level;
    logic [N_BTN-1:0]     press;
    logic                 unused_press;

    state_e               state_q,   state_next;
    logic [REL_W-1:0]     rel_cnt_q, rel_cnt_next;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_next;
    logic [7:0]           seq_q,     seq_next;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .nRst  (nRst),
            .btn_n (bus.btn_n[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    // Buttons above PULSE are debounced for their level only.
    assign unused_press = ^press;

    // Sequencer registers; the reset outputs come straight from rst_out_q.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_HALT;
            rel_cnt_q <= '0;
            rst_out_q <= '0;
            seq_q     <= '0;
        end else begin
            state_q   <= state_next;
            rel_cnt_q <= rel_cnt_next;
            rst_out_q <= rst_out_next;
            seq_q     <= seq_next;
        end
    end

    // Next-state logic: HALT press overrides everything, otherwise act on
    // the events that are meaningful in the current state.
    // NOTE: every output is given a default first so no latch is inferred.
    always_comb begin
        state_next   = state_q;
        rel_cnt_next = rel_cnt_q;
        rst_out_next = rst_out_q;
        seq_next     = seq_q;

        if (press[BTN_HALT]) begin
            state_next   = ST_HALT;
            rel_cnt_next = '0;
            rst_out_next = '0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    rst_out_next = '0;
                    if (press[BTN_RUN]) begin
                        state_next   = ST_RELEASING;
                        rel_cnt_next = '0;
                    end
                end
                ST_RELEASING: begin
                    rel_cnt_next = rel_cnt_q + REL_W'(1);
                    for (int k = 0; k < N_DOMAINS; k++) begin
                        if (rel_cnt_next == REL_W'((k + 1) * STRETCH_CYCLES))
                            rst_out_next[k] = 1'b1;
                    end
                    if (rel_cnt_next == REL_LAST) begin
                        state_next = ST_RUN;
                        seq_next   = seq_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    rst_out_next = '1;
                    if (press[BTN_PULSE]) begin
                        state_next   = ST_RELEASING;
                        rel_cnt_next = '0;
                        rst_out_next = '0;
                    end
                end
                default: begin
                    state_next   = ST_HALT;
                    rel_cnt_next = '0;
                    rst_out_next = '0;
                end
            endcase
        end
    end

    assign bus.nRstOut  = rst_out_q;
    assign bus.btnLevel = level;
    assign bus.state    = state_q;
    assign bus.seqCount = seq_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with DEBOUNCE_CYCLES=4,
// STRETCH_CYCLES=3, N_DOMAINS=2. A button change is applied on a falling
// edge, so the following rising edge is edge 1 of that scenario; outputs
// are sampled 1 ns after rising edges.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int N_BTN = 3;
    localparam int N_DOM = 2;

    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    reset_sequencer_if #(.N_BTN(N_BTN), .N_DOMAINS(N_DOM)) bus ();

    reset_sequencer #(
        .N_BTN           (N_BTN),
        .N_DOMAINS       (N_DOM),
        .DEBOUNCE_CYCLES (4),
        .STRETCH_CYCLES  (3)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        bus.btn_n = '1;
        #12;
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        checks++; if (bus.nRstOut !== 2'b00) begin errors++; $display("FAIL rst_nRstOut: got %b want 00", bus.nRstOut); end
        checks++; if (bus.btnLevel !== 3'b000) begin errors++; $display("FAIL rst_btnLevel: got %b want 000", bus.btnLevel); end
        checks++; if (bus.seqCount !== 8'd0) begin errors++; $display("FAIL rst_seqCount: got %0d want 0", bus.seqCount); end
        @(negedge clk); nRst = 1'b1;
        edges(5);
        checks++; if (bus.state !== 2'd0 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL rst_idle: got state %0d nRstOut %b want 0 00", bus.state, bus.nRstOut); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.btn_n[BTN_RUN] = ~bus.btn_n[BTN_RUN];
            edges(2);
            checks++; if (bus.btnLevel[BTN_RUN] !== 1'b0 || bus.state !== 2'd0) begin errors++; $display("FAIL bounce_%0d: got level %b state %0d want 0 0", i, bus.btnLevel[BTN_RUN], bus.state); end
        end
        edges(8);
        checks++; if (bus.state !== 2'd0 || bus.btnLevel !== 3'b000) begin errors++; $display("FAIL bounce_after: got state %0d level %b want 0 000", bus.state, bus.btnLevel); end
    endtask

    task automatic test_run_release();
        @(negedge clk); bus.btn_n[BTN_RUN] = 1'b0;
        edges(6);
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL run_e6_state: got %0d want 0", bus.state); end
        checks++; if (bus.btnLevel !== 3'b001) begin errors++; $display("FAIL run_e6_level: got %b want 001", bus.btnLevel); end
        edges(1);
        checks++; if (bus.state !== 2'd1 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL run_e7: got state %0d nRstOut %b want 1 00", bus.state, bus.nRstOut); end
        edges(2);
        checks++; if (bus.nRstOut !== 2'b00) begin errors++; $display("FAIL run_e9: got %b want 00", bus.nRstOut); end
        edges(1);
        checks++; if (bus.nRstOut !== 2'b01 || bus.state !== 2'd1) begin errors++; $display("FAIL run_e10: got nRstOut %b state %0d want 01 1", bus.nRstOut, bus.state); end
        edges(2);
        checks++; if (bus.nRstOut !== 2'b01 || bus.state !== 2'd1) begin errors++; $display("FAIL run_e12: got nRstOut %b state %0d want 01 1", bus.nRstOut, bus.state); end
        edges(1);
        checks++; if (bus.nRstOut !== 2'b11 || bus.state !== 2'd2) begin errors++; $display("FAIL run_e13: got nRstOut %b state %0d want 11 2", bus.nRstOut, bus.state); end
        checks++; if (bus.seqCount !== 8'd1) begin errors++; $display("FAIL run_seq: got %0d want 1", bus.seqCount); end
        @(negedge clk); bus.btn_n[BTN_RUN] = 1'b1;
        edges(10);
        checks++; if (bus.state !== 2'd2 || bus.btnLevel !== 3'b000 || bus.nRstOut !== 2'b11) begin errors++; $display("FAIL run_unpress: got state %0d level %b nRstOut %b want 2 000 11", bus.state, bus.btnLevel, bus.nRstOut); end
    endtask

    task automatic test_pulse();
        @(negedge clk); bus.btn_n[BTN_PULSE] = 1'b0;
        edges(6);
        checks++; if (bus.nRstOut !== 2'b11 || bus.state !== 2'd2) begin errors++; $display("FAIL pulse_e6: got nRstOut %b state %0d want 11 2", bus.nRstOut, bus.state); end
        edges(1);
        checks++; if (bus.nRstOut !== 2'b00 || bus.state !== 2'd1) begin errors++; $display("FAIL pulse_e7: got nRstOut %b state %0d want 00 1", bus.nRstOut, bus.state); end
        edges(3);
        checks++; if (bus.nRstOut !== 2'b01) begin errors++; $display("FAIL pulse_e10: got %b want 01", bus.nRstOut); end
        edges(3);
        checks++; if (bus.nRstOut !== 2'b11 || bus.state !== 2'd2 || bus.seqCount !== 8'd2) begin errors++; $display("FAIL pulse_e13: got nRstOut %b state %0d seq %0d want 11 2 2", bus.nRstOut, bus.state, bus.seqCount); end
        @(negedge clk); bus.btn_n[BTN_PULSE] = 1'b1;
        edges(10);
    endtask

    task automatic test_halt_during_release();
        @(negedge clk); bus.btn_n[BTN_PULSE] = 1'b0;
        edges(4);
        @(negedge clk); bus.btn_n[BTN_HALT] = 1'b0;
        edges(6);
        checks++; if (bus.nRstOut !== 2'b01 || bus.state !== 2'd1) begin errors++; $display("FAIL halt_pre: got nRstOut %b state %0d want 01 1", bus.nRstOut, bus.state); end
        edges(1);
        checks++; if (bus.nRstOut !== 2'b00 || bus.state !== 2'd0) begin errors++; $display("FAIL halt_e7: got nRstOut %b state %0d want 00 0", bus.nRstOut, bus.state); end
        checks++; if (bus.seqCount !== 8'd2) begin errors++; $display("FAIL halt_seq: got %0d want 2", bus.seqCount); end
        edges(4);
        checks++; if (bus.nRstOut !== 2'b00 || bus.state !== 2'd0) begin errors++; $display("FAIL halt_hold: got nRstOut %b state %0d want 00 0", bus.nRstOut, bus.state); end
        @(negedge clk); bus.btn_n = '1;
        edges(10);
    endtask

    task automatic test_simultaneous();
        @(negedge clk); bus.btn_n = 3'b100;
        edges(7);
        checks++; if (bus.btnLevel !== 3'b011) begin errors++; $display("FAIL simul_level: got %b want 011", bus.btnLevel); end
        checks++; if (bus.state !== 2'd0 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL simul_e7: got state %0d nRstOut %b want 0 00", bus.state, bus.nRstOut); end
        edges(6);
        checks++; if (bus.state !== 2'd0 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL simul_later: got state %0d nRstOut %b want 0 00", bus.state, bus.nRstOut); end
        @(negedge clk); bus.btn_n = '1;
        edges(10);
    endtask

    task automatic test_run_pulse_together();
        @(negedge clk); bus.btn_n = 3'b010;
        edges(7);
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL rp_halt_e7: got state %0d want 1", bus.state); end
        edges(6);
        checks++; if (bus.state !== 2'd2 || bus.nRstOut !== 2'b11 || bus.seqCount !== 8'd3) begin errors++; $display("FAIL rp_halt_e13: got state %0d nRstOut %b seq %0d want 2 11 3", bus.state, bus.nRstOut, bus.seqCount); end
        @(negedge clk); bus.btn_n = '1;
        edges(10);
        @(negedge clk); bus.btn_n = 3'b010;
        edges(7);
        checks++; if (bus.state !== 2'd1 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL rp_run_e7: got state %0d nRstOut %b want 1 00", bus.state, bus.nRstOut); end
        edges(3);
        checks++; if (bus.nRstOut !== 2'b01) begin errors++; $display("FAIL rp_run_e10: got %b want 01", bus.nRstOut); end
    endtask

    task automatic test_async_reset();
        #2 nRst = 1'b0;
        #1;
        checks++; if (bus.state !== 2'd0 || bus.nRstOut !== 2'b00) begin errors++; $display("FAIL async_ctrl: got state %0d nRstOut %b want 0 00", bus.state, bus.nRstOut); end
        checks++; if (bus.btnLevel !== 3'b000 || bus.seqCount !== 8'd0) begin errors++; $display("FAIL async_stat: got level %b seq %0d want 000 0", bus.btnLevel, bus.seqCount); end
        bus.btn_n = '1;
        @(negedge clk); nRst = 1'b1;
        edges(12);
        checks++; if (bus.state !== 2'd0 || bus.nRstOut !== 2'b00 || bus.seqCount !== 8'd0) begin errors++; $display("FAIL async_after: got state %0d nRstOut %b seq %0d want 0 00 0", bus.state, bus.nRstOut, bus.seqCount); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bounce();
        test_run_release();
        test_pulse();
        test_halt_during_release();
        test_simultaneous();
        test_run_pulse_together();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want completion by 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
